dram_port_arbiter: RTL

//  Shares the single dummy_dram port between NUM_REQ cache controllers (e.g. I-cache and D-cache).

---
 rtl/dram_port_arbiter_pkg.sv | 20 ++
 rtl/dram_port_arbiter_if.sv | 37 +++
 rtl/dram_port_arbiter_rr_pick.sv | 35 +++
 rtl/dram_port_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/dram_port_arbiter_pkg.sv
// Shared types for the DRAM port arbiter: FSM state encoding and LSU op codes.
// Latency: n/a (types only).
// Backpressure: n/a.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    localparam logic LSU_READ  = 1'b0;
    localparam logic LSU_WRITE = 1'b1;

    // Index width for an N-way selector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dram_port_arbiter_if.sv
// Requester-side and DRAM-side signal bundle of the DRAM port arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req_valid until their one-cycle req_ready pulse.
interface dram_port_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 11
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_lsu_op;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_error;
    logic [DATA_WIDTH-1:0]         req_rdata;
    logic [NUM_REQ-1:0]            grant;
    logic                          dram_mem_req;
    logic [ADDR_WIDTH-1:0]         dram_address;
    logic                          dram_lsu_op;
    logic [DATA_WIDTH-1:0]         dram_wdata;
    logic                          dram_mem_ready;
    logic [DATA_WIDTH-1:0]         dram_rdata;

    // Arbiter view.
    modport slave (
        input  req_valid, req_addr, req_lsu_op, req_wdata, dram_mem_ready, dram_rdata,
        output req_ready, req_error, req_rdata, grant,
               dram_mem_req, dram_address, dram_lsu_op, dram_wdata
    );

    // Environment view: cache controllers plus the DRAM model.
    modport master (
        output req_valid, req_addr, req_lsu_op, req_wdata, dram_mem_ready, dram_rdata,
        input  req_ready, req_error, req_rdata, grant,
               dram_mem_req, dram_address, dram_lsu_op, dram_wdata
    );
endinterface

// File: rtl/dram_port_arbiter_rr_pick.sv
// Round-robin picker: first set request scanning upward from last+1, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides when to sample the result.
module rr_pick #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    assign o_any = |i_req;

    // Rotate the priority so the index just after the previous winner is checked first.
    always_comb begin
        logic found;
        int   cand;
        o_gnt = '0;
        o_idx = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(i_last) + k) % N;
            if (!found && i_req[cand]) begin
                found       = 1'b1;
                o_gnt[cand] = 1'b1;
                o_idx       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one DRAM port between NUM_REQ cache controllers, round-robin, one op in flight.
// Latency: request to dram_mem_req 1 cycle; dram_mem_ready to req_ready 1 cycle.
// Backpressure: requests wait until the port returns to IDLE; optional abort via DRAM_ARB_TIMEOUT_EN.
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 11,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    dram_port_arbiter_if.slave  io_bus
);

    localparam int IW = idx_width(NUM_REQ);

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("dram_port_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t              r_state;
    logic [NUM_REQ-1:0]      r_grant;
    logic [NUM_REQ-1:0]      r_ready;
    logic [IW-1:0]           r_last;
    logic                    r_mem_req;
    logic                    r_op;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic [NUM_REQ-1:0]      w_gnt;
    logic [IW-1:0]           w_idx;
    logic                    w_any;

`ifdef DRAM_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0]           r_cnt;
    logic [NUM_REQ-1:0]      r_error;
`endif

    rr_pick #(.N(NUM_REQ)) u_pick (
        .i_req  (io_bus.req_valid),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign io_bus.grant        = r_grant;
    assign io_bus.req_ready    = r_ready;
    assign io_bus.req_rdata    = r_rdata;
    assign io_bus.dram_mem_req = r_mem_req;
    assign io_bus.dram_address = r_addr;
    assign io_bus.dram_lsu_op  = r_op;
    assign io_bus.dram_wdata   = r_wdata;
`ifdef DRAM_ARB_TIMEOUT_EN
    assign io_bus.req_error    = r_error;
`else
    assign io_bus.req_error    = '0;
`endif

    // Arbitration FSM; every output comes straight from a register updated here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ARB_IDLE;
            r_grant   <= '0;
            r_ready   <= '0;
            r_last    <= IW'(NUM_REQ - 1);
            r_mem_req <= 1'b0;
            r_op      <= LSU_READ;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
`ifdef DRAM_ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_error   <= '0;
`endif
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_grant   <= w_gnt;
                        r_last    <= w_idx;
                        r_addr    <= io_bus.req_addr[int'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                        r_op      <= io_bus.req_lsu_op[w_idx];
                        r_wdata   <= io_bus.req_wdata[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
                        r_mem_req <= 1'b1;
                        r_state   <= ARB_BUSY;
`ifdef DRAM_ARB_TIMEOUT_EN
                        r_cnt     <= '0;
`endif
                    end
                end
                ARB_BUSY: begin
                    if (io_bus.dram_mem_ready) begin
                        r_mem_req <= 1'b0;
                        if (r_op == LSU_READ) begin
                            r_rdata <= io_bus.dram_rdata;
                        end
                        r_ready   <= r_grant;
                        r_state   <= ARB_DONE;
`ifdef DRAM_ARB_TIMEOUT_EN
                    end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        // DRAM never answered: release the port and flag the owner.
                        r_mem_req <= 1'b0;
                        r_rdata   <= '0;
                        r_ready   <= r_grant;
                        r_error   <= r_grant;
                        r_state   <= ARB_DONE;
                    end else begin
                        r_cnt     <= r_cnt + 1'b1;
`endif
                    end
                end
                ARB_DONE: begin
                    r_ready   <= '0;
                    r_grant   <= '0;
                    r_state   <= ARB_IDLE;
`ifdef DRAM_ARB_TIMEOUT_EN
                    r_error   <= '0;
`endif
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule
